// File: rtl/program_loader.sv
// Streams a framed program image (sync, 16-bit word count, big-endian data, checksum)
// into instruction memory, holding the processor in reset while a load is in progress.
module program_loader #(
  parameter int unsigned MEMORY_DEPTH   = 32,
  parameter logic [31:0] PROGRAM_BASE   = 32'h0040_0000,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  byte_data,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [15:0] words_loaded
);

  localparam int unsigned WIDX_W = $clog2(MEMORY_DEPTH + 1);
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  SYNC   = 8'hA5;

  typedef enum logic [2:0] {
    IDLE, HDR_HI, HDR_LO, DATA, WRITE, CHECK, DONE, ERROR
  } stateT;

  stateT             state, nextState;
  logic              xfer, startFrame, timedState, timedOut, lastWord;
  logic [15:0]       newCount, frameCount;
  logic [7:0]        countHi, sum;
  logic [1:0]        byteIdx;
  logic [WIDX_W-1:0] wordIdx;
  logic [31:0]       pack;
  logic [TO_W-1:0]   toCnt;
  logic              cpuHoldQ, doneQ, errorQ;
  logic [15:0]       wordsQ;

  assign byte_ready   = (state != WRITE);
  assign xfer         = byte_valid && byte_ready;
  assign mem_we       = (state == WRITE);
  assign mem_addr     = PROGRAM_BASE + (32'(wordIdx) << 2);
  assign mem_wdata    = pack;
  assign cpu_hold     = cpuHoldQ;
  assign load_done    = doneQ;
  assign load_error   = errorQ;
  assign words_loaded = wordsQ;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState  = state;
    newCount   = {countHi, byte_data};
    lastWord   = (32'(wordIdx) + 32'd1 == 32'(frameCount));
    timedState = (state == HDR_HI) || (state == HDR_LO) || (state == DATA) || (state == CHECK);
    timedOut   = timedState && !xfer && (toCnt == TO_W'(TIMEOUT_CYCLES));
    startFrame = xfer && (byte_data == SYNC) &&
                 ((state == IDLE) || (state == DONE) || (state == ERROR));
    case (state)
      IDLE, DONE, ERROR: if (startFrame) nextState = HDR_HI;
      HDR_HI: if (xfer) nextState = HDR_LO;
      HDR_LO: begin
        if (xfer) begin
          if (newCount == '0 || 32'(newCount) > MEMORY_DEPTH) nextState = ERROR;
          else                                                nextState = DATA;
        end
      end
      DATA:  if (xfer && byteIdx == 2'd3) nextState = WRITE;
      WRITE: nextState = lastWord ? CHECK : DATA;
      CHECK: if (xfer) nextState = (byte_data == sum) ? DONE : ERROR;
      default: nextState = IDLE;
    endcase
    if (timedOut) nextState = ERROR;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      countHi    <= '0;
      frameCount <= '0;
      sum        <= '0;
      byteIdx    <= '0;
      wordIdx    <= '0;
      pack       <= '0;
      toCnt      <= '0;
      cpuHoldQ   <= 1'b0;
      doneQ      <= 1'b0;
      errorQ     <= 1'b0;
      wordsQ     <= '0;
    end else begin
      // Idle-gap counter only advances between bytes inside a frame and saturates at the limit.
      if (!timedState || xfer)              toCnt <= '0;
      else if (toCnt != TO_W'(TIMEOUT_CYCLES)) toCnt <= toCnt + 1'b1;

      if (startFrame) begin
        doneQ   <= 1'b0;
        errorQ  <= 1'b0;
        wordsQ  <= '0;
        wordIdx <= '0;
        byteIdx <= '0;
        sum     <= '0;
      end

      case (state)
        HDR_HI: if (xfer) countHi <= byte_data;
        HDR_LO: if (xfer) frameCount <= newCount;
        DATA: begin
          if (xfer) begin
            pack    <= {pack[23:0], byte_data};
            sum     <= sum + byte_data;
            byteIdx <= byteIdx + 1'b1;
          end
        end
        WRITE: begin
          wordsQ <= wordsQ + 1'b1;
          if (!lastWord) wordIdx <= wordIdx + 1'b1;
        end
        default: ;
      endcase

      if (nextState == DONE && state != DONE) doneQ <= 1'b1;
      if (nextState == ERROR)                 errorQ <= 1'b1;
      cpuHoldQ <= !((nextState == IDLE) || (nextState == DONE));
    end
  end

endmodule
